// File: rtl/signed_mac_sequencer_if.sv
// Operand-stream and result handshake bundle for signed_mac_sequencer.
// master drives pairs and takes results; slave is the sequencer.
interface signed_mac_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_acc;
    logic signed [OUT_W-1:0]  out_sat;
    logic                     out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_acc, out_sat, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_acc, out_sat, out_ovf
    );
endinterface

// File: rtl/signed_mac_sequencer.sv
// Dot-product sequencer: one shared signed multiplier feeding a
// wrapping accumulator, result returned raw and saturated.
module signed_mac_sequencer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    signed_mac_sequencer_if.slave bus
);
    localparam int PW = 2 * DATA_W;
    localparam int TW = ACC_W - OUT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [LEN_W-1:0]        rem_q;
    logic signed [PW-1:0]    p_q;
    logic                    p_vld_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    out_valid_q;

    logic                    accept;
    logic signed [PW-1:0]    a_x;
    logic signed [PW-1:0]    b_x;
    logic signed [PW-1:0]    p_d;
    logic [TW-1:0]           top;
    logic                    ovf;

    assign accept = bus.in_valid && (state_q == LOAD);

    // Operands widened explicitly so the product keeps full precision.
    assign a_x = {{DATA_W{bus.in_a[DATA_W-1]}}, bus.in_a};
    assign b_x = {{DATA_W{bus.in_b[DATA_W-1]}}, bus.in_b};
    assign p_d = a_x * b_x;

    assign acc_d = acc_q + {{(ACC_W-PW){p_q[PW-1]}}, p_q};

    // Fits OUT_W only when every bit above the OUT_W sign bit matches it.
    assign top = acc_q[ACC_W-1:OUT_W-1];
    assign ovf = !((&top) || !(|top));

    assign busy          = (state_q != IDLE);
    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf;

    // Clamp toward the nearest representable OUT_W extreme.
    always_comb begin
        bus.out_sat = acc_q[OUT_W-1:0];
        if (ovf) begin
            if (acc_q[ACC_W-1]) begin
                bus.out_sat = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                bus.out_sat = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

    // Sequencer FSM with product pipeline and accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_vld_q <= 1'b0;
            if (p_vld_q) begin
                acc_q <= acc_d;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q <= '0;
                        if (len == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            rem_q   <= len;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        p_q     <= p_d;
                        p_vld_q <= 1'b1;
                        rem_q   <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
